// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - byte handshake between the UART receive FIFO and its consumer
// Purpose: carries the FIFO head byte downstream under a valid/ready handshake.
// Signals:
//   dout       - byte at the FIFO head (driven by master)
//   dout_valid - FIFO holds at least one byte (driven by master)
//   dout_ready - consumer takes dout this cycle (driven by slave)
// Modports: master = receiver/FIFO side, slave = consumer side.
interface uart_rx_fifo_if;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a first-word-fall-through byte FIFO
// Purpose: synchronises the asynchronous serial line, decodes 8N1 frames and queues
// received bytes for a downstream consumer.
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous active-high reset
//   uart_rxp   - asynchronous serial input, idle high
//   rx_bus     - master side of the byte handshake (dout/dout_valid/dout_ready)
//   frame_err  - one-cycle pulse when a stop bit is sampled low
//   overrun    - one-cycle pulse when a received byte is dropped on a full FIFO
//   fifo_count - number of bytes currently held
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 78_750_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        uart_rxp,
  uart_rx_fifo_if.master              rx_bus,
  output logic                        frame_err,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);

  // The IDLE edge that spots the falling line already spends one cycle of the
  // half-bit wait, so the START countdown is one shorter than DIV/2-1. This puts
  // the start-bit sample DIV/2 cycles after the line is first seen low at rx_s.
  localparam logic [CW-1:0] HALF_LOAD  = CW'(DIV / 2 - 2);
  localparam logic [CW-1:0] BIT_LOAD   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic          r_sync1;
  logic          r_rx_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;

  logic w_valid;
  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_wr_en;

  // Two-flop synchroniser; idle-high reset value keeps IDLE from seeing a false start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= uart_rxp;
      r_rx_s  <= r_sync1;
    end
  end

  // A good stop bit pushes on the very edge it is sampled.
  assign w_push  = !reset && (r_state == S_STOP) && (r_cnt == '0) && r_rx_s;
  assign w_valid = (fifo_count != '0);
  assign w_pop   = w_valid && rx_bus.dout_ready;
  assign w_full  = (fifo_count == FULL_COUNT);
  // On a full FIFO a concurrent pop frees the slot the push needs.
  assign w_wr_en = w_push && (!w_full || w_pop);

  assign rx_bus.dout       = r_mem[r_rd_ptr];
  assign rx_bus.dout_valid = w_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_cnt   <= HALF_LOAD;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (r_rx_s) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt     <= BIT_LOAD;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_cnt     <= BIT_LOAD;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (r_rx_s) begin
            r_state <= S_IDLE;
          end else begin
            frame_err <= 1'b1;
            r_state   <= S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          // A held-low line (break) must not retrigger START until it recovers.
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= w_push && !w_wr_en;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_wr_en && !w_pop) begin
        fifo_count <= fifo_count + COUNT_ONE;
      end else if (!w_wr_en && w_pop) begin
        fifo_count <= fifo_count - COUNT_ONE;
      end
    end
  end

endmodule
